// File: rtl/ap_pkg.sv
// Shared types and constants for the associative-processor LUT engine:
// FSM states, command codes, column selects and per-op truth tables.
package ap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE,
    DONE
  } ap_state_t;

  localparam int CMD_W = 3;
  localparam int SEL_W = 2;

  localparam logic [CMD_W-1:0] CMD_OR  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_AND = 3'd1;
  localparam logic [CMD_W-1:0] CMD_XOR = 3'd2;
  localparam logic [CMD_W-1:0] CMD_ADD = 3'd3;

  localparam logic [SEL_W-1:0] COL_A    = 2'd0;
  localparam logic [SEL_W-1:0] COL_B    = 2'd1;
  localparam logic [SEL_W-1:0] COL_C    = 2'd2;
  localparam logic [SEL_W-1:0] COL_NONE = 2'd3;

  // Truth tables indexed by pass number: {a,b} for logic ops, {a,b,cin} for ADD.
  localparam logic [3:0] LUT_OR        = 4'b1110;
  localparam logic [3:0] LUT_AND       = 4'b1000;
  localparam logic [3:0] LUT_XOR       = 4'b0110;
  localparam logic [7:0] LUT_ADD_SUM   = 8'b1001_0110;
  localparam logic [7:0] LUT_ADD_CARRY = 8'b1110_1000;

  function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
    return (c <= CMD_ADD);
  endfunction

  function automatic logic lut_bit(input logic [CMD_W-1:0] c, input logic [2:0] pass);
    logic r;
    case (c)
      CMD_OR:  r = LUT_OR[pass[1:0]];
      CMD_AND: r = LUT_AND[pass[1:0]];
      CMD_XOR: r = LUT_XOR[pass[1:0]];
      CMD_ADD: r = LUT_ADD_SUM[pass];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ap_lut_engine_if.sv
// Host-side bus of the LUT engine: row access strobes, operation request
// and status/interrupt outputs.
interface ap_lut_engine_if #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512
);
  import ap_pkg::*;

  localparam int ADDR_W = $clog2(CELL_QUANT);

  logic [ADDR_W-1:0]    addr_in;
  logic [WORD_SIZE-1:0] data_in;
  logic [SEL_W-1:0]     sel_col;
  logic                 write_en;
  logic                 read_en;
  logic [CMD_W-1:0]     cmd;
  logic                 start;
  logic [WORD_SIZE-1:0] data_out;
  logic                 busy;
  logic                 done_irq;

  modport master (
    output addr_in, data_in, sel_col, write_en, read_en, cmd, start,
    input  data_out, busy, done_irq
  );

  modport slave (
    input  addr_in, data_in, sel_col, write_en, read_en, cmd, start,
    output data_out, busy, done_irq
  );

endinterface

// File: rtl/ap_col.sv
// One associative column: word storage with a host port, a per-row masked
// compare against a key, and a masked bit write into every tagged row.
module ap_col
  import ap_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = $clog2(CELL_QUANT)
) (
  input  logic                  clka,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [WORD_SIZE-1:0]  host_wdata,
  output logic [WORD_SIZE-1:0]  host_rdata,
  input  logic [WORD_SIZE-1:0]  key,
  input  logic [WORD_SIZE-1:0]  mask,
  output logic [CELL_QUANT-1:0] match,
  input  logic                  tag_we,
  input  logic [CELL_QUANT-1:0] tag,
  input  logic [WORD_SIZE-1:0]  wr_mask,
  input  logic                  wr_val
);

  logic [WORD_SIZE-1:0] mem [CELL_QUANT];

  assign host_rdata = mem[host_addr];

  always_comb begin
    match = '0;
    for (int r = 0; r < CELL_QUANT; r++) begin
      match[r] = (((mem[r] ^ key) & mask) == '0);
    end
  end

  // Storage is deliberately not reset; host and tagged writes never overlap
  // because the top blocks host writes while an operation is running.
  always_ff @(posedge clka) begin
    if (host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (tag_we) begin
      for (int r = 0; r < CELL_QUANT; r++) begin
        if (tag[r]) begin
          mem[r] <= (mem[r] & ~wr_mask) | ({WORD_SIZE{wr_val}} & wr_mask);
        end
      end
    end
  end

endmodule

// File: rtl/ap_lut_engine.sv
// Bit-serial associative processor: computes C = A op B on every row at once
// by sweeping bit positions and LUT input patterns with compare/write passes.
module ap_lut_engine
  import ap_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512
) (
  input logic            clka,
  input logic            rst,
  ap_lut_engine_if.slave host
);

  localparam int ADDR_W = $clog2(CELL_QUANT);
  localparam int BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  ap_state_t             state, state_nxt;
  logic [CMD_W-1:0]      cmd_r;
  logic [BIT_W-1:0]      bit_cnt;
  logic [2:0]            pass_cnt;
  logic [WORD_SIZE-1:0]  mask_r;
  logic                  key_a, key_b, key_cin, lut_val, lut_cy;
  logic [CELL_QUANT-1:0] carry, carry_next, carry_upd, carry_ok, tag;
  logic [CELL_QUANT-1:0] match_a, match_b, match_c;
  logic [WORD_SIZE-1:0]  rd_a, rd_b, rd_c;
  logic                  busy, is_add, last_pass, last_bit, host_we;

  assign busy      = (state != IDLE);
  assign host.busy = busy;
  assign is_add    = (cmd_r == CMD_ADD);
  assign last_pass = is_add ? (pass_cnt == 3'd7) : (pass_cnt == 3'd3);
  assign last_bit  = (bit_cnt == BIT_W'(WORD_SIZE - 1));
  assign host_we   = host.write_en && !busy;

  // Carry only participates in the row tag for ADD; logic ops ignore it.
  assign carry_ok  = is_add ? ~(carry ^ {CELL_QUANT{key_cin}}) : {CELL_QUANT{1'b1}};
  assign tag       = match_a & match_b & match_c & carry_ok;
  assign carry_upd = (tag & {CELL_QUANT{lut_cy}}) | (~tag & carry_next);

  ap_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_a (
    .clka(clka), .host_we(host_we && host.sel_col == COL_A), .host_addr(host.addr_in),
    .host_wdata(host.data_in), .host_rdata(rd_a),
    .key({WORD_SIZE{key_a}} & mask_r), .mask(mask_r), .match(match_a),
    .tag_we(1'b0), .tag('0), .wr_mask('0), .wr_val(1'b0)
  );

  ap_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_b (
    .clka(clka), .host_we(host_we && host.sel_col == COL_B), .host_addr(host.addr_in),
    .host_wdata(host.data_in), .host_rdata(rd_b),
    .key({WORD_SIZE{key_b}} & mask_r), .mask(mask_r), .match(match_b),
    .tag_we(1'b0), .tag('0), .wr_mask('0), .wr_val(1'b0)
  );

  // C is never compared (zero mask matches every row); it is the write target.
  ap_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_c (
    .clka(clka), .host_we(host_we && host.sel_col == COL_C), .host_addr(host.addr_in),
    .host_wdata(host.data_in), .host_rdata(rd_c),
    .key('0), .mask('0), .match(match_c),
    .tag_we(state == WRITE), .tag(tag), .wr_mask(mask_r), .wr_val(lut_val)
  );

  always_ff @(posedge clka) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host.start && cmd_legal(host.cmd)) state_nxt = COMPARE;
      COMPARE: state_nxt = WRITE;
      WRITE:   state_nxt = (last_pass && last_bit) ? DONE : COMPARE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counters, registered pass key/mask, carry vectors, host read.
  always_ff @(posedge clka) begin
    if (rst) begin
      cmd_r         <= CMD_OR;
      bit_cnt       <= '0;
      pass_cnt      <= '0;
      mask_r        <= '0;
      key_a         <= 1'b0;
      key_b         <= 1'b0;
      key_cin       <= 1'b0;
      lut_val       <= 1'b0;
      lut_cy        <= 1'b0;
      carry         <= '0;
      carry_next    <= '0;
      host.done_irq <= 1'b0;
      host.data_out <= '0;
    end else begin
      host.done_irq <= (state == DONE);
      if (host.read_en) begin
        case (host.sel_col)
          COL_A:   host.data_out <= rd_a;
          COL_B:   host.data_out <= rd_b;
          COL_C:   host.data_out <= rd_c;
          default: host.data_out <= '0;
        endcase
      end
      case (state)
        IDLE: begin
          if (host.start && cmd_legal(host.cmd)) begin
            cmd_r      <= host.cmd;
            bit_cnt    <= '0;
            pass_cnt   <= '0;
            carry      <= '0;
            carry_next <= '0;
          end
        end
        COMPARE: begin
          mask_r  <= WORD_SIZE'(1) << bit_cnt;
          key_a   <= is_add ? pass_cnt[2] : pass_cnt[1];
          key_b   <= is_add ? pass_cnt[1] : pass_cnt[0];
          key_cin <= pass_cnt[0];
          lut_val <= lut_bit(cmd_r, pass_cnt);
          lut_cy  <= LUT_ADD_CARRY[pass_cnt];
        end
        WRITE: begin
          if (is_add) begin
            carry_next <= carry_upd;
            if (pass_cnt == 3'd7) carry <= carry_upd;
          end
          if (last_pass) begin
            pass_cnt <= '0;
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            pass_cnt <= pass_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_lut_engine.sv
// Scoreboard bench for ap_lut_engine: host reads push expected words to a
// queue and are popped when data_out is sampled; timing checks are inline.
module tb_ap_lut_engine;
  import ap_pkg::*;

  localparam int WS = 8;
  localparam int CQ = 512;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [WS-1:0] exp_q [$];
  logic [WS-1:0] mdl_a [8];
  logic [WS-1:0] mdl_b [8];

  ap_lut_engine_if #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) host ();

  ap_lut_engine #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .clka(clka),
    .rst (rst),
    .host(host)
  );

  always #5 clka = ~clka;

  function automatic logic [WS-1:0] model_op(input logic [2:0] c, input logic [WS-1:0] a,
                                             input logic [WS-1:0] b);
    case (c)
      CMD_OR:  return a | b;
      CMD_AND: return a & b;
      CMD_XOR: return a ^ b;
      default: return WS'(a + b);
    endcase
  endfunction

  task automatic host_write(input logic [1:0] col, input int addr, input logic [WS-1:0] d);
    @(negedge clka);
    host.sel_col  = col;
    host.addr_in  = 9'(addr);
    host.data_in  = d;
    host.write_en = 1'b1;
    @(negedge clka);
    host.write_en = 1'b0;
  endtask

  task automatic read_word(input logic [1:0] col, input int addr, output logic [WS-1:0] v);
    @(negedge clka);
    host.sel_col = col;
    host.addr_in = 9'(addr);
    host.read_en = 1'b1;
    @(posedge clka);
    #1;
    v = host.data_out;
    host.read_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] c, output int lat, output bit seen);
    @(negedge clka);
    host.cmd   = c;
    host.start = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 4000 && !seen; i++) begin
      @(posedge clka);
      #1;
      host.start = 1'b0;
      lat = i;
      if (host.done_irq) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    host.addr_in = '0; host.data_in = '0; host.sel_col = COL_NONE;
    host.write_en = 1'b0; host.read_en = 1'b0; host.cmd = CMD_OR; host.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    rst = 1'b0;
    checks++;
    if (host.busy !== 1'b0 || host.done_irq !== 1'b0 || host.data_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got busy=%b irq=%b dout=%h expected 0 0 00",
               host.busy, host.done_irq, host.data_out);
    end
  endtask

  task automatic test_host_rw();
    logic [WS-1:0] got, exp;
    host_write(COL_A, 7, 8'h11);
    host_write(COL_B, 7, 8'h22);
    exp_q.push_back(8'h11);
    read_word(COL_A, 7, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rd_a7 got %h expected %h", got, exp); end
    // same-cycle write and read of one row returns the previous contents
    @(negedge clka);
    host.sel_col = COL_A; host.addr_in = 9'd7; host.data_in = 8'h33;
    host.write_en = 1'b1; host.read_en = 1'b1;
    exp_q.push_back(8'h11);
    @(posedge clka);
    #1;
    got = host.data_out;
    host.write_en = 1'b0; host.read_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rd_during_wr got %h expected %h", got, exp); end
    host_write(COL_NONE, 7, 8'hEE);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h22);
    read_word(COL_A, 7, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rd_a7_new got %h expected %h", got, exp); end
    read_word(COL_B, 7, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rd_b7 got %h expected %h", got, exp); end
    read_word(COL_NONE, 7, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rd_none got %h expected %h", got, exp); end
    read_word(COL_B, 7, got);
    host.addr_in = 9'd3;
    repeat (2) @(posedge clka);
    #1;
    got = host.data_out;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL dout_hold got %h expected %h", got, exp); end
  endtask

  task automatic test_or();
    logic [WS-1:0] got, exp;
    int lat;
    bit seen;
    mdl_a[5] = 8'h3C; mdl_b[5] = 8'h0F;
    host_write(COL_A, 5, mdl_a[5]);
    host_write(COL_B, 5, mdl_b[5]);
    run_op(CMD_OR, lat, seen);
    checks++;
    if (!seen || lat != 66) begin
      errors++; $display("[TB] FAIL or_latency got %0d (seen=%0b) expected 66", lat, seen);
    end
    checks++;
    if (host.busy !== 1'b0) begin errors++; $display("[TB] FAIL or_busy_after got %b expected 0", host.busy); end
    exp_q.push_back(model_op(CMD_OR, mdl_a[5], mdl_b[5]));
    read_word(COL_C, 5, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL or_c5 got %h expected %h", got, exp); end
  endtask

  task automatic test_xor();
    logic [WS-1:0] got, exp;
    int lat;
    bit seen;
    mdl_a[0] = 8'hAA; mdl_b[0] = 8'hFF; mdl_a[1] = 8'h55; mdl_b[1] = 8'h0F;
    for (int r = 0; r < 2; r++) begin
      host_write(COL_A, r, mdl_a[r]);
      host_write(COL_B, r, mdl_b[r]);
    end
    run_op(CMD_XOR, lat, seen);
    checks++;
    if (!seen || lat != 66) begin
      errors++; $display("[TB] FAIL xor_latency got %0d (seen=%0b) expected 66", lat, seen);
    end
    for (int r = 0; r < 2; r++) exp_q.push_back(model_op(CMD_XOR, mdl_a[r], mdl_b[r]));
    for (int r = 0; r < 2; r++) begin
      read_word(COL_C, r, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL xor_c row %0d got %h expected %h", r, got, exp); end
    end
  endtask

  task automatic test_add();
    logic [WS-1:0] got, exp;
    int lat;
    bit seen;
    mdl_a[2] = 8'hC8; mdl_b[2] = 8'h64;
    mdl_a[3] = 8'hFF; mdl_b[3] = 8'h01;
    mdl_a[4] = 8'($urandom_range(0, 255)); mdl_b[4] = 8'($urandom_range(0, 255));
    for (int r = 2; r < 5; r++) begin
      host_write(COL_A, r, mdl_a[r]);
      host_write(COL_B, r, mdl_b[r]);
    end
    run_op(CMD_ADD, lat, seen);
    checks++;
    if (!seen || lat != 130) begin
      errors++; $display("[TB] FAIL add_latency got %0d (seen=%0b) expected 130", lat, seen);
    end
    for (int r = 0; r < 6; r++) exp_q.push_back(model_op(CMD_ADD, mdl_a[r], mdl_b[r]));
    for (int r = 0; r < 6; r++) begin
      read_word(COL_C, r, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL add_c row %0d got %h expected %h", r, got, exp); end
    end
  endtask

  task automatic test_busy_guard();
    logic [WS-1:0] got, exp;
    int n_done = 0;
    int first_lat = 0;
    @(negedge clka);
    host.cmd = CMD_AND;
    host.start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clka);
      #1;
      host.start = 1'b0;
      host.write_en = 1'b0;
      if (host.done_irq) begin
        n_done++;
        if (first_lat == 0) first_lat = cyc;
      end
      if (cyc == 10) begin host.start = 1'b1; host.cmd = CMD_OR; end
      if (cyc == 20) begin
        host.sel_col = COL_A; host.addr_in = 9'd0; host.data_in = 8'h99; host.write_en = 1'b1;
      end
    end
    checks++;
    if (n_done != 1 || first_lat != 66) begin
      errors++; $display("[TB] FAIL busy_guard_irq got %0d pulses first at %0d expected 1 at 66", n_done, first_lat);
    end
    exp_q.push_back(mdl_a[0]);
    read_word(COL_A, 0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL busy_wr_blocked got %h expected %h", got, exp); end
    for (int r = 0; r < 6; r++) exp_q.push_back(model_op(CMD_AND, mdl_a[r], mdl_b[r]));
    for (int r = 0; r < 6; r++) begin
      read_word(COL_C, r, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL and_c row %0d got %h expected %h", r, got, exp); end
    end
  endtask

  task automatic test_reset_abort();
    logic [WS-1:0] got, exp;
    int lat;
    bit seen;
    bit busy_mid = 1'b0;
    @(negedge clka);
    host.cmd = CMD_ADD;
    host.start = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(posedge clka);
      #1;
      host.start = 1'b0;
      if (cyc == 6) begin
        host.read_en = 1'b0;
        got = host.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rd_while_busy got %h expected %h", got, exp); end
      end
      if (cyc == 5) begin
        host.sel_col = COL_A; host.addr_in = 9'd5; host.read_en = 1'b1;
        exp_q.push_back(mdl_a[5]);
      end
      if (cyc == 19) busy_mid = host.busy;
    end
    checks++;
    if (busy_mid !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_op got %b expected 1", busy_mid); end
    rst = 1'b1;
    @(posedge clka);
    #1;
    rst = 1'b0;
    checks++;
    if (host.busy !== 1'b0 || host.done_irq !== 1'b0 || host.data_out !== '0) begin
      errors++;
      $display("[TB] FAIL abort_state got busy=%b irq=%b dout=%h expected 0 0 00",
               host.busy, host.done_irq, host.data_out);
    end
    run_op(CMD_OR, lat, seen);
    checks++;
    if (!seen || lat != 66) begin
      errors++; $display("[TB] FAIL rerun_latency got %0d (seen=%0b) expected 66", lat, seen);
    end
    for (int r = 0; r < 6; r++) exp_q.push_back(model_op(CMD_OR, mdl_a[r], mdl_b[r]));
    for (int r = 0; r < 6; r++) begin
      read_word(COL_C, r, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL rerun_c row %0d got %h expected %h", r, got, exp); end
    end
    run_op(CMD_ADD, lat, seen);
    for (int r = 0; r < 6; r++) exp_q.push_back(model_op(CMD_ADD, mdl_a[r], mdl_b[r]));
    for (int r = 0; r < 6; r++) begin
      read_word(COL_C, r, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL readd_c row %0d got %h expected %h", r, got, exp); end
    end
  endtask

  task automatic test_illegal_cmd();
    bit busy_seen = 1'b0;
    bit irq_seen  = 1'b0;
    logic [2:0] bad [2];
    bad[0] = 3'd5;
    bad[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clka);
      host.cmd = bad[k];
      host.start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(posedge clka);
        #1;
        host.start = 1'b0;
        if (host.busy) busy_seen = 1'b1;
        if (host.done_irq) irq_seen = 1'b1;
      end
    end
    checks++;
    if (busy_seen || irq_seen) begin
      errors++; $display("[TB] FAIL illegal_cmd got busy=%b irq=%b expected 0 0", busy_seen, irq_seen);
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      mdl_a[r] = '0;
      mdl_b[r] = '0;
    end
    test_reset();
    test_host_rw();
    test_or();
    test_xor();
    test_add();
    test_busy_guard();
    test_reset_abort();
    test_illegal_cmd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
